uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Controller for the UART receive path. It generates the 16x oversampling tick for the receive frame FSM and enables, clears and recovers that FSM. Completed bytes go into a small first-word-fall-through FIFO with a valid/ready output. Frame errors, timeouts and overruns are tracked for the host.

## Interface
Parameters:
- DATA_W, 8, frame data width.
- DIV_W, 16, width of the baud divisor.
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
- TIMEOUT_TICKS, 176, oversample ticks allowed in RECEIVING before forced recovery.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- areset_n  in  1  asynchronous active-low reset.
- rx_en  in  1  receive enable.
- clr  in  1  synchronous clear of the whole block.
- baud_div  in  DIV_W  clk cycles per tick, minus 1.
- fsm_done  in  1  frame FSM done pulse.
- fsm_err  in  1  frame FSM stop-bit error pulse.
- fsm_busy  in  1  frame FSM not idle.
- fsm_data  in  DATA_W  deserialized byte; valid when fsm_done=1.
- fsm_en  out  1  frame FSM enable.
- fsm_reset  out  1  frame FSM synchronous reset.
- tick  out  1  oversample tick, one-cycle pulse.
- m_data  out  DATA_W  FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts head.
- overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- frm_err_cnt  out  8  saturating count of frame errors and timeouts.
- level  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
- **Tick generator:**
  - div_cnt runs while state is not DISABLED.
  - When div_cnt==baud_div: tick=1, div_cnt wraps to 0. Otherwise div_cnt increments.
  - baud_div=0 gives tick every cycle.
  - If div_cnt>baud_div after a divisor change, div_cnt goes to 0 with no tick.
- **State machine:**
  - DISABLED: fsm_en=0, fsm_reset=1. Goes to IDLE when rx_en=1.
  - IDLE: fsm_en=1. Goes to RECEIVING when fsm_busy=1.
  - RECEIVING: fsm_en=1.
    - fsm_done: push fsm_data, go to IDLE.
    - fsm_err: frm_err_cnt+1, go to RECOVER.
    - Watchdog expiry: frm_err_cnt+1, go to RECOVER.
    - If fsm_done and fsm_err are both 1, fsm_err wins and there is no push.
  - RECOVER: fsm_reset=1 for exactly one cycle, then IDLE.
  - rx_en=0 in any state sends the block to DISABLED on the next cycle. A partial frame is discarded and the FIFO contents are kept.
- **FIFO:**
  - First-word fall-through: m_valid=(level!=0), m_data=entry at read pointer.
  - Pop on m_valid&&m_ready.
  - Push is accepted when not full, or when full with a pop in the same cycle; level is unchanged in the second case.
  - Push when full with no pop: the byte is dropped and overrun is set.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- **Counters:** frm_err_cnt saturates at 255. overrun clears only on clr or reset.
- **clr:**
  - Takes priority over everything except areset_n.
  - Empties the FIFO and zeroes overrun, frm_err_cnt, div_cnt and the watchdog.
  - Sets state to IDLE if rx_en=1, otherwise DISABLED.
  - fsm_reset=1 in the clr cycle.

## Timing
- Reset values:
  - State DISABLED; div_cnt=0; tick=0.
  - fsm_en=0, fsm_reset=1.
  - m_valid=0, m_data=0, level=0.
  - overrun=0, frm_err_cnt=0.
- fsm_en and fsm_reset are combinational from the state register and clr. tick is registered.
- First tick arrives baud_div+1 cycles after leaving DISABLED.
- Push latency: fsm_done in cycle N gives m_valid=1 and level+1 in cycle N+1.
- Pop: m_valid&&m_ready in cycle N gives the new head in N+1.
- overrun and frm_err_cnt update in the cycle after the causing event.
- Watchdog:
  - Counts ticks while in RECEIVING and clears on entry to RECEIVING.
  - Expiry is the cycle the count reaches TIMEOUT_TICKS.
  - RECOVER follows in the next cycle.
- areset_n mid-frame takes the block to the reset values immediately, with no handshake.

## Configuration
- UART_RX_CTRL_WATCHDOG_EN defined:
  - Watchdog counter present; timeout behaviour as above.
- UART_RX_CTRL_WATCHDOG_EN undefined:
  - No watchdog logic; TIMEOUT_TICKS is ignored.
  - RECEIVING exits only on fsm_done, fsm_err or rx_en=0.
  - frm_err_cnt counts fsm_err only.

## Test plan
- baud_div=3, rx_en=1 -> tick every 4th cycle, first tick 4 cycles after leaving DISABLED; change baud_div to 1 while div_cnt=3 -> div_cnt to 0, no tick, then a tick every 2 cycles.
- Frame FSM model sends 0xA5 and 0x3C, m_ready=1 -> m_data 0xA5 then 0x3C, each valid one cycle after its fsm_done; overrun=0.
- m_ready=0, five frames with DEPTH=4 -> level=4, fifth byte dropped, overrun=1; drain gives bytes 1-4 in order. Repeat full with push and pop in the same cycle -> level stays 4, no overrun.
- fsm_err pulse -> frm_err_cnt=1, fsm_reset high for exactly one cycle, state IDLE; 300 errors -> count stays at 255.
- With the macro defined, fsm_busy held high with no done or err -> after 176 ticks, RECOVER and frm_err_cnt+1. Without the macro -> stays in RECEIVING.
- rx_en dropped mid-frame -> fsm_en=0 and fsm_reset=1 next cycle, FIFO kept. clr with 3 bytes queued -> level=0, m_valid=0, counters 0 the next cycle.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller with baud tick, frame FSM supervision, FWFT byte FIFO and error tracking.
// Define UART_RX_CTRL_WATCHDOG_EN to force recovery of frames stuck in RECEIVING for TIMEOUT_TICKS ticks.
module uart_rx_ctrl #(
    parameter int DATA_W = 8,
    parameter int DIV_W = 16,
    parameter int DEPTH = 4,
    parameter int TIMEOUT_TICKS = 176,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              rx_en,
    input  logic              clr,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              fsm_done,
    input  logic              fsm_err,
    input  logic              fsm_busy,
    input  logic [DATA_W-1:0] fsm_data,
    output logic              fsm_en,
    output logic              fsm_reset,
    output logic              tick,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              overrun,
    output logic [7:0]        frm_err_cnt,
    output logic [AW:0]       level
);
    typedef enum logic [1:0] {DISABLED, IDLE, RECEIVING, RECOVER} state_e;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_TICKS < 1) begin : g_bad_param
        $error("uart_rx_ctrl: DEPTH must be a power of 2 >= 2 and TIMEOUT_TICKS >= 1");
    end

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick_q, tick_d;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       level_q, level_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              rx_active, timeout, push_req, push, pop, full;

`ifdef UART_RX_CTRL_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_TICKS + 1);
    logic [WW-1:0] wd_q, wd_d;
    // Held at zero outside RECEIVING, so every entry starts a fresh count.
    always_comb begin
        wd_d = (clr || state_q != RECEIVING) ? '0 : wd_q + WW'(tick_q);
        timeout = state_q == RECEIVING && wd_q == WW'(TIMEOUT_TICKS);
    end
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) wd_q <= '0;
        else wd_q <= wd_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        rx_active = state_q == RECEIVING && rx_en && !clr;
        pop = level_q != '0 && m_ready;
        full = level_q == (AW + 1)'(DEPTH);
        // A simultaneous error or timeout wins over done: the byte is not trusted.
        push_req = rx_active && fsm_done && !fsm_err && !timeout;
        push = push_req && (!full || pop);
        tick_d = !clr && state_q != DISABLED && div_q == baud_div;
        div_d = (clr || state_q == DISABLED || div_q >= baud_div) ? '0 : div_q + 1'b1;
        state_d = state_q;
        if (clr) state_d = rx_en ? IDLE : DISABLED;
        else if (!rx_en) state_d = DISABLED;
        else begin
            case (state_q)
                DISABLED:  state_d = IDLE;
                IDLE:      state_d = fsm_busy ? RECEIVING : IDLE;
                RECEIVING: state_d = (fsm_err || timeout) ? RECOVER : fsm_done ? IDLE : RECEIVING;
                default:   state_d = IDLE;
            endcase
        end
        wr_d = clr ? '0 : push ? wr_q + 1'b1 : wr_q;
        rd_d = clr ? '0 : pop ? rd_q + 1'b1 : rd_q;
        level_d = clr ? '0 : (push && !pop) ? level_q + 1'b1 : (pop && !push) ? level_q - 1'b1 : level_q;
        overrun_d = !clr && (overrun_q || (push_req && full && !pop));
        err_d = clr ? '0 : (rx_active && (fsm_err || timeout) && err_q != 8'hFF) ? err_q + 1'b1 : err_q;
        fsm_en = !clr && (state_q == IDLE || state_q == RECEIVING);
        fsm_reset = clr || state_q == DISABLED || state_q == RECOVER;
        m_valid = level_q != '0;
        m_data = m_valid ? mem_q[rd_q] : '0;
        tick = tick_q;
        overrun = overrun_q;
        frm_err_cnt = err_q;
        level = level_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= fsm_data;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= DISABLED;
            div_q     <= '0;
            tick_q    <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl; expected bytes are queued when a frame completes.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 4;
    logic clk = 0, areset_n = 0, rx_en = 0, clr = 0;
    logic fsm_done = 0, fsm_err = 0, fsm_busy = 0, m_ready = 0;
    logic [15:0] baud_div = 16'd3;
    logic [7:0] fsm_data = 8'h00;
    logic fsm_en, fsm_reset, tick, m_valid, overrun;
    logic [7:0] m_data, frm_err_cnt;
    logic [2:0] level;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int pass_cnt = 0, chk_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_W(8), .DIV_W(16), .DEPTH(DEPTH), .TIMEOUT_TICKS(176)) dut (
        .clk(clk), .areset_n(areset_n), .rx_en(rx_en), .clr(clr), .baud_div(baud_div),
        .fsm_done(fsm_done), .fsm_err(fsm_err), .fsm_busy(fsm_busy), .fsm_data(fsm_data),
        .fsm_en(fsm_en), .fsm_reset(fsm_reset), .tick(tick), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .overrun(overrun), .frm_err_cnt(frm_err_cnt), .level(level)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        fsm_busy = 1; step();
        fsm_busy = 0; fsm_done = 1; fsm_data = b; step();
        fsm_done = 0;
    endtask

    task automatic test_reset;
        #2;
        chk_cnt++; if (fsm_en !== 1'b0) $display("FAIL rst_fsm_en got %b exp 0", fsm_en); else pass_cnt++;
        chk_cnt++; if (fsm_reset !== 1'b1) $display("FAIL rst_fsm_reset got %b exp 1", fsm_reset); else pass_cnt++;
        chk_cnt++; if (tick !== 1'b0) $display("FAIL rst_tick got %b exp 0", tick); else pass_cnt++;
        chk_cnt++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b exp 0", m_valid); else pass_cnt++;
        chk_cnt++; if (m_data !== 8'h00) $display("FAIL rst_m_data got %h exp 00", m_data); else pass_cnt++;
        chk_cnt++; if (level !== 3'd0) $display("FAIL rst_level got %0d exp 0", level); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b exp 0", overrun); else pass_cnt++;
        chk_cnt++; if (frm_err_cnt !== 8'd0) $display("FAIL rst_err_cnt got %0d exp 0", frm_err_cnt); else pass_cnt++;
        step(); areset_n = 1; step();
    endtask

    task automatic test_tick;
        logic e;
        baud_div = 16'd3; rx_en = 1; step();
        for (int i = 1; i <= 12; i++) begin
            step();
            e = (i <= 7) ? (i % 4 == 0) : (i == 10 || i == 12);
            chk_cnt++; if (tick !== e) $display("FAIL tick[%0d] got %b exp %b", i, tick, e); else pass_cnt++;
            if (i == 7) baud_div = 16'd1;
        end
        baud_div = 16'd0;
    endtask

    task automatic test_frames;
        logic [7:0] bytes [2];
        bytes[0] = 8'hA5; bytes[1] = 8'h3C;
        m_ready = 1;
        for (int k = 0; k < 2; k++) begin
            fsm_busy = 1; step();
            fsm_busy = 0; fsm_done = 1; fsm_data = bytes[k]; exp_q.push_back(bytes[k]);
            chk_cnt++; if (m_valid !== 1'b0) $display("FAIL frame_early_valid[%0d] got %b exp 0", k, m_valid); else pass_cnt++;
            step(); fsm_done = 0;
            exp_b = exp_q.pop_front();
            chk_cnt++; if (m_valid !== 1'b1) $display("FAIL frame_valid[%0d] got %b exp 1", k, m_valid); else pass_cnt++;
            chk_cnt++; if (m_data !== exp_b) $display("FAIL frame_data[%0d] got %h exp %h", k, m_data, exp_b); else pass_cnt++;
            step();
        end
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL frame_overrun got %b exp 0", overrun); else pass_cnt++;
        m_ready = 0;
    endtask

    task automatic test_overrun;
        int ml = 0;
        logic eo = 0;
        for (int k = 0; k < 5; k++) begin
            exp_b = 8'(8'h11 * (k + 1));
            if (ml < DEPTH) begin exp_q.push_back(exp_b); ml++; end else eo = 1;
            send(exp_b);
            chk_cnt++; if (overrun !== eo) $display("FAIL ovr_flag[%0d] got %b exp %b", k, overrun, eo); else pass_cnt++;
        end
        chk_cnt++; if (level !== 3'd4) $display("FAIL ovr_level got %0d exp 4", level); else pass_cnt++;
        m_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = exp_q.pop_front();
            chk_cnt++; if (m_valid !== 1'b1 || m_data !== exp_b) $display("FAIL ovr_drain[%0d] valid %b data %h exp %h", i, m_valid, m_data, exp_b); else pass_cnt++;
            step();
        end
        m_ready = 0;
        chk_cnt++; if (level !== 3'd0 || m_valid !== 1'b0) $display("FAIL ovr_empty level %0d valid %b exp 0 0", level, m_valid); else pass_cnt++;
        clr = 1; step(); clr = 0;
        for (int k = 0; k < DEPTH; k++) begin
            exp_b = 8'(8'h61 + k); exp_q.push_back(exp_b); send(exp_b);
        end
        fsm_busy = 1; step();
        fsm_busy = 0; fsm_done = 1; fsm_data = 8'h65; exp_q.push_back(8'h65); m_ready = 1;
        exp_b = exp_q.pop_front();
        chk_cnt++; if (m_data !== exp_b) $display("FAIL full_pop_head got %h exp %h", m_data, exp_b); else pass_cnt++;
        step(); fsm_done = 0; m_ready = 0;
        chk_cnt++; if (level !== 3'd4) $display("FAIL full_pp_level got %0d exp 4", level); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL full_pp_overrun got %b exp 0", overrun); else pass_cnt++;
        m_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = exp_q.pop_front();
            chk_cnt++; if (m_valid !== 1'b1 || m_data !== exp_b) $display("FAIL full_pp_drain[%0d] valid %b data %h exp %h", i, m_valid, m_data, exp_b); else pass_cnt++;
            step();
        end
        m_ready = 0;
    endtask

    task automatic test_errors;
        clr = 1; step(); clr = 0;
        fsm_busy = 1; step();
        fsm_busy = 0; fsm_done = 1; fsm_err = 1; fsm_data = 8'hEE; step();
        fsm_done = 0; fsm_err = 0;
        chk_cnt++; if (frm_err_cnt !== 8'd1) $display("FAIL err_cnt got %0d exp 1", frm_err_cnt); else pass_cnt++;
        chk_cnt++; if (fsm_reset !== 1'b1 || fsm_en !== 1'b0) $display("FAIL err_recover reset %b en %b exp 1 0", fsm_reset, fsm_en); else pass_cnt++;
        chk_cnt++; if (level !== 3'd0) $display("FAIL err_no_push level %0d exp 0", level); else pass_cnt++;
        step();
        chk_cnt++; if (fsm_reset !== 1'b0 || fsm_en !== 1'b1) $display("FAIL err_idle reset %b en %b exp 0 1", fsm_reset, fsm_en); else pass_cnt++;
        for (int i = 0; i < 299; i++) begin
            fsm_busy = 1; step();
            fsm_busy = 0; fsm_err = 1; step();
            fsm_err = 0; step();
            if (i == 253) begin
                chk_cnt++; if (frm_err_cnt !== 8'd255) $display("FAIL err_cnt_255 got %0d exp 255", frm_err_cnt); else pass_cnt++;
            end
        end
        chk_cnt++; if (frm_err_cnt !== 8'd255) $display("FAIL err_cnt_sat got %0d exp 255", frm_err_cnt); else pass_cnt++;
    endtask

    task automatic test_watchdog;
        int n = 0;
        baud_div = 16'd0; clr = 1; step(); clr = 0; step(); step();
        fsm_busy = 1; step();
`ifdef UART_RX_CTRL_WATCHDOG_EN
        for (int i = 1; i <= 400 && n == 0; i++) begin
            step();
            if (fsm_reset) n = i;
        end
        chk_cnt++; if (n !== 177) $display("FAIL wd_expiry cycle got %0d exp 177", n); else pass_cnt++;
        chk_cnt++; if (frm_err_cnt !== 8'd1) $display("FAIL wd_err_cnt got %0d exp 1", frm_err_cnt); else pass_cnt++;
        fsm_busy = 0; step();
`else
        for (int i = 1; i <= 300; i++) begin
            step();
            if (fsm_reset || !fsm_en) n++;
        end
        chk_cnt++; if (n !== 0) $display("FAIL wd_absent recover cycles got %0d exp 0", n); else pass_cnt++;
        chk_cnt++; if (frm_err_cnt !== 8'd0) $display("FAIL wd_absent err_cnt got %0d exp 0", frm_err_cnt); else pass_cnt++;
        fsm_busy = 0;
`endif
    endtask

    task automatic test_disable_clr;
        clr = 1; step(); clr = 0; exp_q.delete();
        fsm_busy = 1; step(); fsm_busy = 0; fsm_err = 1; step(); fsm_err = 0; step();
        for (int k = 0; k < 3; k++) begin
            exp_b = 8'(8'hC0 + k); exp_q.push_back(exp_b); send(exp_b);
        end
        fsm_busy = 1; step(); rx_en = 0; step();
        chk_cnt++; if (fsm_en !== 1'b0 || fsm_reset !== 1'b1) $display("FAIL dis_fsm en %b reset %b exp 0 1", fsm_en, fsm_reset); else pass_cnt++;
        chk_cnt++; if (level !== 3'd3 || m_data !== exp_q[0]) $display("FAIL dis_fifo_kept level %0d head %h exp 3 %h", level, m_data, exp_q[0]); else pass_cnt++;
        fsm_busy = 0; rx_en = 1; step();
        chk_cnt++; if (fsm_en !== 1'b1 || frm_err_cnt !== 8'd1) $display("FAIL reen en %b err %0d exp 1 1", fsm_en, frm_err_cnt); else pass_cnt++;
        clr = 1; #1;
        chk_cnt++; if (fsm_reset !== 1'b1 || fsm_en !== 1'b0) $display("FAIL clr_cycle reset %b en %b exp 1 0", fsm_reset, fsm_en); else pass_cnt++;
        step(); clr = 0; exp_q.delete();
        chk_cnt++; if (level !== 3'd0 || m_valid !== 1'b0) $display("FAIL clr_fifo level %0d valid %b exp 0 0", level, m_valid); else pass_cnt++;
        chk_cnt++; if (frm_err_cnt !== 8'd0 || overrun !== 1'b0) $display("FAIL clr_counters err %0d ovr %b exp 0 0", frm_err_cnt, overrun); else pass_cnt++;
    endtask

    task automatic test_async_reset;
        send(8'h77);
        fsm_busy = 1; step(); #2;
        areset_n = 0; #1;
        chk_cnt++; if (fsm_en !== 1'b0 || fsm_reset !== 1'b1) $display("FAIL areset_fsm en %b reset %b exp 0 1", fsm_en, fsm_reset); else pass_cnt++;
        chk_cnt++; if (level !== 3'd0 || m_valid !== 1'b0) $display("FAIL areset_fifo level %0d valid %b exp 0 0", level, m_valid); else pass_cnt++;
        fsm_busy = 0; step(); areset_n = 1; step();
    endtask

    initial begin
        test_reset();
        test_tick();
        test_frames();
        test_overrun();
        test_errors();
        test_watchdog();
        test_disable_clr();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
